// File: rtl/ysyx_23060096_pkg.sv
// Shared definitions for the write-back stage: FSM state encoding and load size codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ysyx_23060096_pkg;

    // Write-back unit control states
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_LOAD = 2'd1,
        ST_WRITE     = 2'd2
    } wbu_state_e;

    // Load access size as carried by in_ld_size
    localparam logic [1:0] LD_B = 2'd0;
    localparam logic [1:0] LD_H = 2'd1;
    localparam logic [1:0] LD_W = 2'd2;

endpackage

// File: rtl/ysyx_23060096_ld_ext.sv
// Load alignment/extension: picks the addressed byte/half lane of an aligned load word and extends it.
// Latency: purely combinational.
// Backpressure: none (no handshake).
//
// Ports: rdata (aligned word from LSU), size (LD_B/LD_H/LD_W), ld_unsigned (zero-extend when 1),
//        addr_lo (low address bits selecting the lane), data (extended result).
module ysyx_23060096_ld_ext
    import ysyx_23060096_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            size,
    input  logic                  ld_unsigned,
    input  logic [1:0]            addr_lo,
    output logic [DATA_WIDTH-1:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Half lane is selected by addr_lo[1] only; addr_lo[0] is ignored for halves.
    assign byte_lane = rdata[{addr_lo, 3'b000} +: 8];
    assign half_lane = rdata[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        data = rdata;
        case (size)
            LD_B: data = {{(DATA_WIDTH-8){byte_lane[7] & ~ld_unsigned}}, byte_lane};
            LD_H: data = {{(DATA_WIDTH-16){half_lane[15] & ~ld_unsigned}}, half_lane};
            default: data = rdata; // LD_W (and unused code 3) pass the whole word through
        endcase
    end

endmodule

// File: rtl/ysyx_23060096_wbu.sv
// Write-back unit: accepts one EXU result, waits for load data if needed, writes the register file and retires.
// Latency: ALU result written 1 cycle after transfer; load written 1 cycle after lsu_rvalid.
// Backpressure: in_ready is high only in IDLE, so at most one instruction is in flight.
//
// Ports: clk/rstn (async active-low); in_* EXU result + load descriptor (valid/ready);
//        lsu_rvalid/lsu_rdata load return; rf_waddr/rf_wdata/rf_w_en register-file write;
//        commit_valid/commit_pc retire pulse. With YSYX_23060096_WBU_INSTRET_EN defined an
//        extra 64-bit instret output counts retired instructions.
module ysyx_23060096_wbu
    import ysyx_23060096_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_rd_wen,
    input  logic [DATA_WIDTH-1:0] in_result,
    input  logic [31:0]           in_pc,
    input  logic                  in_is_load,
    input  logic [1:0]            in_ld_size,
    input  logic                  in_ld_unsigned,
    input  logic [1:0]            in_addr_lo,
    input  logic                  lsu_rvalid,
    input  logic [DATA_WIDTH-1:0] lsu_rdata,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  rf_w_en,
    output logic                  commit_valid,
    output logic [31:0]           commit_pc
`ifdef YSYX_23060096_WBU_INSTRET_EN
    ,
    output logic [63:0]           instret
`endif
);

    wbu_state_e            state;
    logic [ADDR_WIDTH-1:0] rd_q;
    logic                  wen_q;
    logic [31:0]           pc_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [1:0]            lo_q;
    logic [DATA_WIDTH-1:0] ld_data;

    ysyx_23060096_ld_ext #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ld_ext (
        .rdata       (lsu_rdata),
        .size        (size_q),
        .ld_unsigned (uns_q),
        .addr_lo     (lo_q),
        .data        (ld_data)
    );

    // rf_waddr/rf_wdata/commit_pc are only loaded on entry to WRITE, so they hold
    // their last value in every other state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= ST_IDLE;
            in_ready     <= 1'b1;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            rf_w_en      <= 1'b0;
            commit_valid <= 1'b0;
            commit_pc    <= '0;
            rd_q         <= '0;
            wen_q        <= 1'b0;
            pc_q         <= '0;
            size_q       <= LD_W;
            uns_q        <= 1'b0;
            lo_q         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        rd_q     <= in_rd;
                        wen_q    <= in_rd_wen;
                        pc_q     <= in_pc;
                        size_q   <= in_ld_size;
                        uns_q    <= in_ld_unsigned;
                        lo_q     <= in_addr_lo;
                        if (in_is_load) begin
                            state <= ST_WAIT_LOAD;
                        end else begin
                            // ALU result goes straight to the write port: written next cycle
                            state        <= ST_WRITE;
                            rf_waddr     <= in_rd;
                            rf_wdata     <= in_result;
                            rf_w_en      <= in_rd_wen && (in_rd != '0);
                            commit_valid <= 1'b1;
                            commit_pc    <= in_pc;
                        end
                    end
                end
                ST_WAIT_LOAD: begin
                    if (lsu_rvalid) begin
                        state        <= ST_WRITE;
                        rf_waddr     <= rd_q;
                        rf_wdata     <= ld_data;
                        rf_w_en      <= wen_q && (rd_q != '0);
                        commit_valid <= 1'b1;
                        commit_pc    <= pc_q;
                    end
                end
                ST_WRITE: begin
                    state        <= ST_IDLE;
                    in_ready     <= 1'b1;
                    rf_w_en      <= 1'b0;
                    commit_valid <= 1'b0;
                end
                default: begin
                    state        <= ST_IDLE;
                    in_ready     <= 1'b1;
                    rf_w_en      <= 1'b0;
                    commit_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef YSYX_23060096_WBU_INSTRET_EN
    // Counts the cycle after each retire pulse; wraps naturally at 2^64.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            instret <= '0;
        end else if (commit_valid) begin
            instret <= instret + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_23060096_wbu.sv
// Bench for the write-back unit: directed cases plus randomized ALU/load traffic against a reference model.
// Latency: n/a.
// Backpressure: driver waits on in_ready with a bounded cycle budget.
module tb_ysyx_23060096_wbu;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_rd_wen;
    logic [31:0] in_result;
    logic [31:0] in_pc;
    logic        in_is_load;
    logic [1:0]  in_ld_size;
    logic        in_ld_unsigned;
    logic [1:0]  in_addr_lo;
    logic        lsu_rvalid;
    logic [31:0] lsu_rdata;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rf_w_en;
    logic        commit_valid;
    logic [31:0] commit_pc;
`ifdef YSYX_23060096_WBU_INSTRET_EN
    logic [63:0] instret;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference state: last write-port address/data and number of retirements since reset
    logic [4:0]  last_waddr;
    logic [31:0] last_wdata;
    longint unsigned commits;

    always #5 clk = ~clk;

    ysyx_23060096_wbu #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_rd          (in_rd),
        .in_rd_wen      (in_rd_wen),
        .in_result      (in_result),
        .in_pc          (in_pc),
        .in_is_load     (in_is_load),
        .in_ld_size     (in_ld_size),
        .in_ld_unsigned (in_ld_unsigned),
        .in_addr_lo     (in_addr_lo),
        .lsu_rvalid     (lsu_rvalid),
        .lsu_rdata      (lsu_rdata),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .rf_w_en        (rf_w_en),
        .commit_valid   (commit_valid),
        .commit_pc      (commit_pc)
`ifdef YSYX_23060096_WBU_INSTRET_EN
        ,
        .instret        (instret)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Load extension from first principles: shift the lane down, mask, then sign-fill by arithmetic.
    function automatic logic [31:0] ref_ld(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] lo, input logic u);
        longint unsigned v;
        if (sz == 2'd0) begin
            v = (longint'(w) >> (8 * int'(lo))) & 64'hFF;
            if (!u && v >= 128) v = v + 64'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (longint'(w) >> (lo >= 2'd2 ? 16 : 0)) & 64'hFFFF;
            if (!u && v >= 32768) v = v + 64'hFFFF_0000;
        end else begin
            v = longint'(w);
        end
        return v[31:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        if (!in_ready) chk("ready_timeout", 64'(in_ready), 64'd1);
    endtask

    task automatic expect_write(input logic [4:0] rd, input logic wen, input logic [31:0] data,
                                input logic [31:0] pc);
        chk("wr_en",     64'(rf_w_en),      64'(wen && rd != 5'd0));
        chk("commit",    64'(commit_valid), 64'd1);
        chk("commit_pc", 64'(commit_pc),    64'(pc));
        chk("waddr",     64'(rf_waddr),     64'(rd));
        chk("wdata",     64'(rf_wdata),     64'(data));
        chk("rdy_write", 64'(in_ready),     64'd0);
        last_waddr = rd;
        last_wdata = data;
        commits++;
    endtask

    task automatic expect_idle();
        chk("idle_wen",    64'(rf_w_en),      64'd0);
        chk("idle_commit", 64'(commit_valid), 64'd0);
        chk("idle_ready",  64'(in_ready),     64'd1);
        chk("hold_waddr",  64'(rf_waddr),     64'(last_waddr));
        chk("hold_wdata",  64'(rf_wdata),     64'(last_wdata));
    endtask

    task automatic alu_op(input logic [4:0] rd, input logic wen, input logic [31:0] res,
                          input logic [31:0] pc);
        wait_ready();
        in_valid = 1'b1; in_is_load = 1'b0;
        in_rd = rd; in_rd_wen = wen; in_result = res; in_pc = pc;
        step();
        in_valid = 1'b0; in_result = $urandom;
        expect_write(rd, wen, res, pc);
        step();
        expect_idle();
    endtask

    task automatic load_op(input logic [4:0] rd, input logic wen, input logic [1:0] sz,
                           input logic [1:0] lo, input logic u, input logic [31:0] pc,
                           input logic [31:0] word, input int dly);
        wait_ready();
        in_valid = 1'b1; in_is_load = 1'b1;
        in_rd = rd; in_rd_wen = wen; in_pc = pc; in_result = $urandom;
        in_ld_size = sz; in_addr_lo = lo; in_ld_unsigned = u;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < dly; i++) begin
            chk("wait_ready",  64'(in_ready),     64'd0);
            chk("wait_wen",    64'(rf_w_en),      64'd0);
            chk("wait_commit", 64'(commit_valid), 64'd0);
            step();
        end
        lsu_rvalid = 1'b1; lsu_rdata = word;
        step();
        lsu_rvalid = 1'b0; lsu_rdata = $urandom;
        expect_write(rd, wen, ref_ld(word, sz, lo, u), pc);
        step();
        expect_idle();
    endtask

    task automatic check_reset_outputs();
        chk("rst_wen",    64'(rf_w_en),      64'd0);
        chk("rst_waddr",  64'(rf_waddr),     64'd0);
        chk("rst_wdata",  64'(rf_wdata),     64'd0);
        chk("rst_commit", 64'(commit_valid), 64'd0);
        chk("rst_cpc",    64'(commit_pc),    64'd0);
`ifdef YSYX_23060096_WBU_INSTRET_EN
        chk("rst_instret", instret, 64'd0);
`endif
    endtask

    initial begin
        rstn = 1'b0; in_valid = 1'b0; in_rd = '0; in_rd_wen = 1'b0; in_result = '0;
        in_pc = '0; in_is_load = 1'b0; in_ld_size = 2'd0; in_ld_unsigned = 1'b0;
        in_addr_lo = 2'd0; lsu_rvalid = 1'b0; lsu_rdata = '0;
        last_waddr = '0; last_wdata = '0; commits = 0;

        step(); step();
        check_reset_outputs();
        rstn = 1'b1;
        step();
        chk("rst_ready", 64'(in_ready), 64'd1);

        // Back-to-back ALU ops with in_valid held: writes two cycles apart
        in_valid = 1'b1; in_is_load = 1'b0;
        in_rd = 5'd3; in_rd_wen = 1'b1; in_result = 32'h1111_2222; in_pc = 32'h8000_0000;
        step();
        expect_write(5'd3, 1'b1, 32'h1111_2222, 32'h8000_0000);
        in_rd = 5'd4; in_result = 32'h3333_4444; in_pc = 32'h8000_0004;
        step();
        expect_idle();
        step();
        in_valid = 1'b0;
        expect_write(5'd4, 1'b1, 32'h3333_4444, 32'h8000_0004);
        step();
        expect_idle();
`ifdef YSYX_23060096_WBU_INSTRET_EN
        chk("instret_b2b", instret, 64'd2);
`endif

        alu_op(5'd5, 1'b1, 32'hDEAD_BEEF, 32'h8000_0010);
        alu_op(5'd0, 1'b1, 32'h1234_5678, 32'h8000_0014);
        alu_op(5'd7, 1'b0, 32'hCAFE_F00D, 32'h8000_0018);
        load_op(5'd9, 1'b1, 2'd0, 2'd3, 1'b0, 32'h8000_001C, 32'h80FF_FF00, 4);
        load_op(5'd10, 1'b1, 2'd1, 2'd2, 1'b1, 32'h8000_0020, 32'h8001_1234, 1);
        load_op(5'd11, 1'b1, 2'd2, 2'd3, 1'b0, 32'h8000_0024, 32'hA5A5_5A5A, 0);

        // lsu_rvalid while idle must be ignored
        lsu_rvalid = 1'b1; lsu_rdata = 32'hFFFF_FFFF;
        step();
        lsu_rvalid = 1'b0;
        expect_idle();

        // Reset during WAIT_LOAD discards the pending load
        in_valid = 1'b1; in_is_load = 1'b1; in_rd = 5'd12; in_rd_wen = 1'b1;
        in_ld_size = 2'd2; in_pc = 32'h8000_0030;
        step();
        in_valid = 1'b0;
        step();
        #2 rstn = 1'b0;
        #1 check_reset_outputs();
        last_waddr = '0; last_wdata = '0; commits = 0;
        step();
        rstn = 1'b1;
        lsu_rvalid = 1'b1; lsu_rdata = 32'h7777_7777;
        step();
        lsu_rvalid = 1'b0;
        expect_idle();
        step();
        expect_idle();

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            logic [4:0]  rd;
            logic        wen;
            logic [31:0] pc;
            rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            wen = 1'($urandom_range(0, 3) != 0);
            pc  = $urandom;
            if ($urandom_range(0, 1) == 0)
                alu_op(rd, wen, $urandom, pc);
            else
                load_op(rd, wen, 2'($urandom_range(0, 2)), 2'($urandom), 1'($urandom), pc,
                        $urandom, $urandom_range(0, 5));
        end

`ifdef YSYX_23060096_WBU_INSTRET_EN
        chk("instret_final", instret, 64'(commits));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_23060096_wbu.md
YSYX_23060096_WBU -- requirements
Module: ysyx_23060096_wbu

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, register index width (2^ADDR_WIDTH registers).
REQ-003 SHALL have port clk, input, 1, sole clock; all state on posedge.
REQ-004 SHALL have port rstn, input, 1; one clock, reset asynchronous active-low.
REQ-005 SHALL have port in_valid, input, 1: EXU result valid.
REQ-006 SHALL have port in_ready, output, 1: WBU accepts the EXU result.
REQ-007 SHALL have inputs in_rd (ADDR_WIDTH), in_rd_wen (1), in_result (DATA_WIDTH), in_pc (32): destination index, write intent, ALU result, instruction PC.
REQ-008 SHALL have inputs in_is_load (1), in_ld_size (2; 0=byte, 1=half, 2=word), in_ld_unsigned (1), in_addr_lo (2): load descriptor.
REQ-009 SHALL have inputs lsu_rvalid (1) and lsu_rdata (DATA_WIDTH): aligned load word return.
REQ-010 SHALL have outputs rf_waddr (ADDR_WIDTH), rf_wdata (DATA_WIDTH), rf_w_en (1): register-file write port.
REQ-011 SHALL have outputs commit_valid (1) and commit_pc (32): one-cycle retire pulse and its PC.

Function
REQ-012 SHALL implement states IDLE, WAIT_LOAD, WRITE, all state in registered outputs.
REQ-013 SHALL set in_ready=1 only in IDLE; a transfer occurs when in_valid && in_ready.
REQ-014 SHALL, on a transfer with in_is_load=0, latch rd/wen/result/pc and go to WRITE.
REQ-015 SHALL, on a transfer with in_is_load=1, latch descriptor and go to WAIT_LOAD.
REQ-016 SHALL, in WAIT_LOAD, hold until lsu_rvalid=1, then capture the extended load data and go to WRITE; lsu_rvalid outside WAIT_LOAD is ignored.
REQ-017 SHALL extract byte lane in_addr_lo (byte) or half lane in_addr_lo[1] (half), sign-extending unless in_ld_unsigned=1; word ignores in_addr_lo.
REQ-018 SHALL, in WRITE, assert rf_w_en for exactly one cycle with rf_waddr=rd, rf_wdata=data, then return to IDLE.
REQ-019 SHALL force rf_w_en=0 when rd==0 or rd_wen=0; commit still occurs.
REQ-020 SHALL pulse commit_valid in the WRITE cycle with commit_pc = latched pc.
REQ-021 SHALL give latency: ALU result written 1 cycle after transfer; load written 1 cycle after lsu_rvalid.
REQ-022 SHALL hold rf_waddr/rf_wdata stable outside WRITE (last value) and keep rf_w_en=0.

Reset
REQ-023 SHALL, while rstn=0, force state=IDLE, rf_w_en=0, rf_waddr=0, rf_wdata=0, commit_valid=0, commit_pc=0; in_ready=1 after release.
REQ-024 SHALL discard any pending ALU or load result when reset asserts mid-operation; no write after release.

Configuration
REQ-025 SHALL, with YSYX_23060096_WBU_INSTRET_EN defined, add output instret (64), reset 0, incremented by 1 per commit_valid, wrapping at 2^64.
REQ-026 SHALL, without YSYX_23060096_WBU_INSTRET_EN, omit the instret port and counter entirely.

Structure
REQ-027 SHALL place state encoding and ld_size constants (LD_B, LD_H, LD_W) in shared package ysyx_23060096_pkg.
REQ-028 SHALL put load alignment/extension in combinational sub-module ysyx_23060096_ld_ext.

Verification
REQ-029 SHALL cover ALU write: in_rd=5, in_result=0xDEADBEEF, wen=1 -> next cycle rf_w_en=1, rf_waddr=5, rf_wdata=0xDEADBEEF, commit_valid=1.
REQ-030 SHALL cover x0 suppression: in_rd=0, wen=1 -> rf_w_en stays 0, commit_valid=1.
REQ-031 SHALL cover signed byte load: size=0, addr_lo=3, lsu_rdata=0x80FF_FF00 after 4 wait cycles -> rf_wdata=0xFFFFFF80, in_ready=0 during wait.
REQ-032 SHALL cover unsigned half load: size=1, addr_lo=2, unsigned=1, lsu_rdata=0x8001_1234 -> rf_wdata=0x00008001.
REQ-033 SHALL cover mid-load reset: rstn low in WAIT_LOAD, then lsu_rvalid=1 -> no rf_w_en, no commit, state IDLE.
REQ-034 SHALL cover back-to-back: in_valid held with two ALU ops -> two writes 2 cycles apart, instret=2 when YSYX_23060096_WBU_INSTRET_EN is defined.
